// File: rtl/sonar_pkg.sv
// Shared sonar constants, timing helpers and transmit FSM states.
// Also used by the receive beamformer for its delay math.
package sonar_pkg;

    localparam int unsigned PROD_WIDTH = 40;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIRE,
        QUIET
    } tx_state_t;

    function automatic int unsigned half_period(input int unsigned clk_freq,
                                                input int unsigned target_freq);
        return clk_freq / (2 * target_freq);
    endfunction

    function automatic int unsigned delay_per_elem(input int unsigned spacing_mm,
                                                   input int unsigned clk_freq,
                                                   input int unsigned speed_mm_s);
        longint unsigned num;
        num = 64'(spacing_mm) * 64'(clk_freq);
        return 32'(num / 64'(speed_mm_s));
    endfunction

endpackage

// File: rtl/tx_element_channel.sv
// One transmit element: starts its burst when the shared fire counter reaches
// its delay, toggles every HALF_PERIOD cycles and stops after BURST_DURATION.
module tx_element_channel #(
    parameter int unsigned CNT_W          = 24,
    parameter int unsigned DELAY_WIDTH    = 16,
    parameter int unsigned BURST_DURATION = 524288,
    parameter int unsigned HALF_PERIOD    = 1250
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [CNT_W-1:0]       fire_cnt,
    input  logic [DELAY_WIDTH-1:0] delay,
    input  logic                   start,
    output logic                   tx,
    output logic                   active
);
    localparam int unsigned CMP_W = ((CNT_W > DELAY_WIDTH) ? CNT_W : DELAY_WIDTH) + 1;
    localparam int unsigned HW    = $clog2(HALF_PERIOD + 1);

    logic [CMP_W-1:0] cnt_ext;
    logic [CMP_W-1:0] start_at;
    logic [CMP_W-1:0] stop_at;
    logic [HW-1:0]    half_cnt;

    assign cnt_ext  = CMP_W'(fire_cnt);
    assign start_at = CMP_W'(delay);
    assign stop_at  = start_at + CMP_W'(BURST_DURATION);

    // Stop wins over start so a zero-length burst never emits a pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx       <= 1'b0;
            active   <= 1'b0;
            half_cnt <= '0;
        end else if (!start || cnt_ext == stop_at) begin
            tx       <= 1'b0;
            active   <= 1'b0;
            half_cnt <= '0;
        end else if (cnt_ext == start_at) begin
            tx       <= 1'b1;
            active   <= 1'b1;
            half_cnt <= '0;
        end else if (active) begin
            if (half_cnt == HW'(HALF_PERIOD - 1)) begin
                tx       <= ~tx;
                half_cnt <= '0;
            end else begin
                half_cnt <= half_cnt + HW'(1);
            end
        end
    end

endmodule

// File: rtl/transmit_beamformer.sv
// Transmit beamformer: once per ping period computes per-element steering delays
// and fires a delayed square-wave burst on every transducer element.
module transmit_beamformer
    import sonar_pkg::*;
#(
    parameter int unsigned PERIOD_DURATION  = 16777216,
    parameter int unsigned BURST_DURATION   = 524288,
    parameter int unsigned NUM_TRANSMITTERS = 4,
    parameter int unsigned ELEMENT_SPACING  = 9,
    parameter int unsigned SPEED_OF_SOUND   = 343000,
    parameter int unsigned TARGET_FREQ      = 40000,
    parameter int unsigned CLK_FREQ         = 100000000,
    parameter int unsigned SIN_WIDTH        = 17,
    parameter int unsigned DELAY_WIDTH      = 16
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        enable_in,
    input  logic [SIN_WIDTH-1:0]        sin_theta,
    input  logic                        sign_bit,
    output logic [NUM_TRANSMITTERS-1:0] tx_out,
    output logic                        burst_active_out,
    output logic                        period_start_out,
    output logic                        busy_out
);
    localparam int unsigned HALF_PERIOD    = half_period(CLK_FREQ, TARGET_FREQ);
    localparam int unsigned DELAY_PER_ELEM = delay_per_elem(ELEMENT_SPACING, CLK_FREQ, SPEED_OF_SOUND);
    localparam int unsigned CNT_W          = $clog2(PERIOD_DURATION);
    localparam int unsigned IDX_W          = (NUM_TRANSMITTERS > 1) ? $clog2(NUM_TRANSMITTERS) : 1;
    localparam int unsigned CMP_W          = ((CNT_W > DELAY_WIDTH) ? CNT_W : DELAY_WIDTH) + 1;
    localparam logic [SIN_WIDTH-1:0] SIN_ONE = {1'b1, {(SIN_WIDTH-1){1'b0}}};

    tx_state_t state;
    tx_state_t state_next;

    logic                        start_period;
    logic                        firing;
    logic                        fire_end;
    logic                        period_end;
    logic [CNT_W-1:0]            period_cnt;
    logic [CNT_W-1:0]            fire_cnt;
    logic [IDX_W-1:0]            calc_idx;
    logic [IDX_W-1:0]            calc_k;
    logic [SIN_WIDTH-1:0]        sin_lat;
    logic                        sign_lat;
    logic [DELAY_WIDTH-1:0]      delay [NUM_TRANSMITTERS];
    logic [DELAY_WIDTH-1:0]      max_delay;
    logic [DELAY_WIDTH-1:0]      delay_calc;
    logic [PROD_WIDTH-1:0]       product;
    logic [NUM_TRANSMITTERS-1:0] active;

    assign firing     = (state == FIRE);
    assign period_end = (period_cnt == CNT_W'(PERIOD_DURATION - 1));
    assign fire_end   = (CMP_W'(fire_cnt) == CMP_W'(max_delay) + CMP_W'(BURST_DURATION));

    always_comb begin
        state_next   = state;
        start_period = 1'b0;
        unique case (state)
            IDLE: begin
                if (enable_in) begin
                    start_period = 1'b1;
                    state_next   = CALC;
                end
            end
            CALC: begin
                if (calc_idx == IDX_W'(NUM_TRANSMITTERS - 1)) state_next = FIRE;
            end
            FIRE: begin
                if (fire_end) state_next = QUIET;
            end
            QUIET: begin
                if (period_end) begin
                    if (enable_in) begin
                        start_period = 1'b1;
                        state_next   = CALC;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // One shared multiplier walks the elements, one per CALC cycle.
    always_comb begin
        calc_k     = sign_lat ? IDX_W'(NUM_TRANSMITTERS - 1) - calc_idx : calc_idx;
        product    = PROD_WIDTH'(DELAY_PER_ELEM) * PROD_WIDTH'(calc_k) * PROD_WIDTH'(sin_lat);
        delay_calc = DELAY_WIDTH'(product >> (SIN_WIDTH - 1));
    end

    always_comb begin
        max_delay = '0;
        for (int unsigned i = 0; i < NUM_TRANSMITTERS; i++) begin
            if (delay[i] > max_delay) max_delay = delay[i];
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state            <= IDLE;
            period_start_out <= 1'b0;
            period_cnt       <= '0;
            fire_cnt         <= '0;
            calc_idx         <= '0;
            sin_lat          <= '0;
            sign_lat         <= 1'b0;
            for (int unsigned i = 0; i < NUM_TRANSMITTERS; i++) delay[i] <= '0;
        end else begin
            state            <= state_next;
            period_start_out <= start_period;
            period_cnt       <= (start_period || state_next == IDLE) ? '0 : period_cnt + CNT_W'(1);
            fire_cnt         <= firing ? fire_cnt + CNT_W'(1) : '0;
            calc_idx         <= (state == CALC) ? calc_idx + IDX_W'(1) : '0;
            if (state == CALC) delay[calc_idx] <= delay_calc;
            if (start_period) begin
                sin_lat  <= (sin_theta > SIN_ONE) ? SIN_ONE : sin_theta;
                sign_lat <= sign_bit;
            end
        end
    end

    for (genvar g = 0; g < NUM_TRANSMITTERS; g++) begin : g_chan
        tx_element_channel #(
            .CNT_W         (CNT_W),
            .DELAY_WIDTH   (DELAY_WIDTH),
            .BURST_DURATION(BURST_DURATION),
            .HALF_PERIOD   (HALF_PERIOD)
        ) u_chan (
            .clk     (clk_in),
            .rst_n   (rst_in),
            .fire_cnt(fire_cnt),
            .delay   (delay[g]),
            .start   (firing),
            .tx      (tx_out[g]),
            .active  (active[g])
        );
    end

    assign burst_active_out = |active;
    assign busy_out         = (state != IDLE);

endmodule
